// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB phase sequencer emitting per-phase write strobes.
// Latency: ALU 4, branch/jump 3, store 4+w, load 5+w cycles fetch-to-retire (w = dm_ack wait).
// Backpressure: run gates FETCH; dm_ack stalls MEM, DM_TO bounds the stall (bus_err + HALT).
//
// Optional feature: define SEQ_PERF_CNT_EN to add the cycle_cnt/retire_cnt perf counters.
// Instruction codes mirror the INST_* values of the core's defines.v.

module mc_sequencer #(
  parameter int DM_TO = 16,  // max cycles dm_req waits for dm_ack; 0 = wait forever
  parameter int CNT_W = 32   // perf counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       dec_inst,
  input  logic             dm_ack,
  output logic             ir_write_en,
  output logic             pc_write_en,
  output logic             gpr_write_gt,
  output logic             dm_write_gt,
  output logic             dm_req,
  output logic             retire,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  // Instruction codes; anything not listed here is executed as an ALU-class op
  // (EXEC -> WB) and its GPR write is masked by the external control word.
  localparam logic [5:0] INST_ADDU  = 6'h01;
  localparam logic [5:0] INST_SUBU  = 6'h02;
  localparam logic [5:0] INST_AND   = 6'h03;
  localparam logic [5:0] INST_OR    = 6'h04;
  localparam logic [5:0] INST_SLT   = 6'h05;
  localparam logic [5:0] INST_ADDIU = 6'h06;
  localparam logic [5:0] INST_LUI   = 6'h07;
  localparam logic [5:0] INST_LW    = 6'h08;
  localparam logic [5:0] INST_LB    = 6'h09;
  localparam logic [5:0] INST_SW    = 6'h0A;
  localparam logic [5:0] INST_SB    = 6'h0B;
  localparam logic [5:0] INST_BEQ   = 6'h0C;
  localparam logic [5:0] INST_J     = 6'h0D;
  localparam logic [5:0] INST_JR    = 6'h0E;
  localparam logic [5:0] INST_JAL   = 6'h0F;
  localparam logic [5:0] INST_HLT   = 6'h3F;

  // Timeout counter only needs to reach DM_TO-1; keep at least one bit so the
  // DM_TO=0 (no timeout) build still elaborates cleanly.
  localparam int             TO_W    = (DM_TO > 1) ? $clog2(DM_TO) : 1;
  localparam bit             TO_EN   = (DM_TO > 0);
  localparam logic [TO_W-1:0] TO_LAST = (DM_TO > 0) ? TO_W'(DM_TO - 1) : '0;

  // Encoding is visible on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            bus_err_q;

  logic is_load;
  logic is_store;
  logic is_br;
  logic is_jal;
  logic is_hlt;
  logic is_mem;
  logic to_expire;

  // Classify the decoded instruction into the groups that steer the phase walk.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_hlt   = 1'b0;
    unique case (dec_inst)
      INST_LW, INST_LB:          is_load  = 1'b1;
      INST_SW, INST_SB:          is_store = 1'b1;
      INST_BEQ, INST_J, INST_JR: is_br    = 1'b1;
      INST_JAL:                  is_jal   = 1'b1;
      INST_HLT:                  is_hlt   = 1'b1;
      INST_ADDU, INST_SUBU, INST_AND, INST_OR,
      INST_SLT, INST_ADDIU, INST_LUI: ;
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  // Timeout fires on the last permitted MEM cycle that sees no dm_ack.
  always_comb begin
    to_expire = TO_EN && (to_cnt == TO_LAST);
  end

  // Phase state machine, DM wait counter and sticky bus error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_FETCH;
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run) state <= ST_DECODE;
        end
        ST_DECODE: begin
          state <= is_hlt ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          if (is_br || is_jal) state <= ST_FETCH;
          else if (is_mem)     state <= ST_MEM;
          else                 state <= ST_WB;
        end
        ST_MEM: begin
          if (dm_ack) begin
            // Stores commit here; loads still need the WB phase for the GPR write.
            to_cnt <= '0;
            state  <= is_store ? ST_FETCH : ST_WB;
          end else if (to_expire) begin
            to_cnt    <= '0;
            bus_err_q <= 1'b1;
            state     <= ST_HALT;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_FETCH;
        end
        ST_HALT: begin
          // Absorbing: only reset leaves HALT.
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Strobes decoded from the current phase; run/dm_ack only qualify the
  // single-cycle FETCH and MEM commits, dec_inst only picks the instruction flavour.
  always_comb begin
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    gpr_write_gt = 1'b0;
    dm_write_gt  = 1'b0;
    dm_req       = 1'b0;
    halted       = 1'b0;
    case (state)
      ST_FETCH: begin
        // Reset holds state at FETCH, so keep IR closed while reset is high.
        ir_write_en = run & ~reset;
      end
      ST_EXEC: begin
        pc_write_en  = is_br | is_jal;
        gpr_write_gt = is_jal;
      end
      ST_MEM: begin
        dm_req      = 1'b1;
        dm_write_gt = is_store;
        pc_write_en = is_store & dm_ack;
      end
      ST_WB: begin
        gpr_write_gt = 1'b1;
        pc_write_en  = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
    retire  = pc_write_en;
    bus_err = bus_err_q;
    state_o = state;
  end

`ifdef SEQ_PERF_CNT_EN
  // Free-running cycle and retire counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) retire_cnt <= retire_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: directed scenarios plus a randomized instruction stream
// checked cycle by cycle against a phase-list model built from the instruction class.
// DUT uses DM_TO=4 so the timeout path is reachable in a short run.

module tb_mc_sequencer;

  localparam int DM_TO = 4;
  localparam int CNT_W = 32;

  localparam logic [5:0] INST_ADDU = 6'h01;
  localparam logic [5:0] INST_LW   = 6'h08;
  localparam logic [5:0] INST_LB   = 6'h09;
  localparam logic [5:0] INST_SW   = 6'h0A;
  localparam logic [5:0] INST_SB   = 6'h0B;
  localparam logic [5:0] INST_BEQ  = 6'h0C;
  localparam logic [5:0] INST_J    = 6'h0D;
  localparam logic [5:0] INST_JR   = 6'h0E;
  localparam logic [5:0] INST_JAL  = 6'h0F;
  localparam logic [5:0] INST_HLT  = 6'h3F;

  typedef enum {C_ALU, C_BR, C_JAL, C_LD, C_ST, C_HLT} cls_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic [5:0] dec_inst = 6'd0;
  logic dm_ack = 1'b0;
  logic ir_write_en, pc_write_en, gpr_write_gt, dm_write_gt, dm_req;
  logic retire, halted, bus_err;
  logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc_since_rst = 0;
  int ret_since_rst = 0;

  mc_sequencer #(.DM_TO(DM_TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .dec_inst(dec_inst), .dm_ack(dm_ack),
    .ir_write_en(ir_write_en), .pc_write_en(pc_write_en), .gpr_write_gt(gpr_write_gt),
    .dm_write_gt(dm_write_gt), .dm_req(dm_req), .retire(retire), .halted(halted),
    .bus_err(bus_err), .state_o(state_o)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ir, pc, gpr, dmw, req, retire, halted, bus_err, state}
  function automatic logic [10:0] obs_vec();
    return {ir_write_en, pc_write_en, gpr_write_gt, dm_write_gt, dm_req,
            retire, halted, bus_err, state_o};
  endfunction

  // Expected vector; retire always equals pc_write_en.
  function automatic logic [10:0] ev(input logic ir, input logic pc, input logic gpr,
                                     input logic dmw, input logic req, input logic hlt,
                                     input logic err, input logic [2:0] st);
    return {ir, pc, gpr, dmw, req, pc, hlt, err, st};
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic [5:0] rinst();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic cls_t cls_of(input logic [5:0] code);
    case (code)
      INST_LW, INST_LB:          return C_LD;
      INST_SW, INST_SB:          return C_ST;
      INST_BEQ, INST_J, INST_JR: return C_BR;
      INST_JAL:                  return C_JAL;
      INST_HLT:                  return C_HLT;
      default:                   return C_ALU;
    endcase
  endfunction

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input string tag, input logic run_v, input logic ack_v,
                      input logic [5:0] inst_v, input logic [10:0] exp, output logic rtr);
    run = run_v;
    dm_ack = ack_v;
    dec_inst = inst_v;
    @(negedge clk);
    chk(tag, {21'd0, obs_vec()}, {21'd0, exp});
    rtr = retire;
    @(posedge clk);
    #1;
    cyc_since_rst++;
    if (exp[9]) ret_since_rst++;
  endtask

  task automatic track(input logic r, inout int n, inout int lat);
    n++;
    if (r && lat == 0) lat = n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b1;
    dm_ack = 1'b1;
    dec_inst = INST_SW;
    #1;
    chk("reset_out", {21'd0, obs_vec()}, 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    chk("reset_retire_cnt", retire_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("reset_hold", {21'd0, obs_vec()}, 32'd0);
    reset = 1'b0;
    run = 1'b0;
    dm_ack = 1'b0;
    cyc_since_rst = 0;
    ret_since_rst = 0;
  endtask

  // Walk one non-HLT instruction through its phases; w = MEM cycles before ack.
  task automatic run_inst(input logic [5:0] code, input int w, input int idle);
    cls_t c;
    logic r, st;
    int n, lat, exp_lat;
    c = cls_of(code);
    st = (c == C_ST);
    n = 0;
    lat = 0;
    for (int i = 0; i < idle; i++)
      step("idle", 1'b0, rb(), rinst(), ev(0, 0, 0, 0, 0, 0, 0, 3'd0), r);
    step("fetch", 1'b1, rb(), rinst(), ev(1, 0, 0, 0, 0, 0, 0, 3'd0), r);
    track(r, n, lat);
    step("decode", rb(), rb(), code, ev(0, 0, 0, 0, 0, 0, 0, 3'd1), r);
    track(r, n, lat);
    case (c)
      C_BR: begin
        step("exec_br", rb(), rb(), code, ev(0, 1, 0, 0, 0, 0, 0, 3'd2), r);
        track(r, n, lat);
      end
      C_JAL: begin
        step("exec_jal", rb(), rb(), code, ev(0, 1, 1, 0, 0, 0, 0, 3'd2), r);
        track(r, n, lat);
      end
      C_LD, C_ST: begin
        step("exec_mem", rb(), rb(), code, ev(0, 0, 0, 0, 0, 0, 0, 3'd2), r);
        track(r, n, lat);
        for (int k = 0; k <= w; k++) begin
          step("mem", rb(), (k == w), code, ev(0, st && (k == w), 0, st, 1, 0, 0, 3'd3), r);
          track(r, n, lat);
        end
        if (c == C_LD) begin
          step("wb_ld", rb(), rb(), code, ev(0, 1, 1, 0, 0, 0, 0, 3'd4), r);
          track(r, n, lat);
        end
      end
      default: begin
        step("exec_alu", rb(), rb(), code, ev(0, 0, 0, 0, 0, 0, 0, 3'd2), r);
        track(r, n, lat);
        step("wb_alu", rb(), rb(), code, ev(0, 1, 1, 0, 0, 0, 0, 3'd4), r);
        track(r, n, lat);
      end
    endcase
    case (c)
      C_BR, C_JAL: exp_lat = 3;
      C_ST:        exp_lat = 4 + w;
      C_LD:        exp_lat = 5 + w;
      default:     exp_lat = 4;
    endcase
    chk("latency", lat, exp_lat);
`ifdef SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, cyc_since_rst);
    chk("retire_cnt", retire_cnt, ret_since_rst);
`endif
  endtask

  initial begin
    logic r;
    logic [5:0] code;
    @(posedge clk);
    #1;
    do_reset();

    // Directed: ALU, long-wait load, branch then store, jal, boundary-wait store, load.
    run_inst(INST_ADDU, 0, 0);
    run_inst(INST_LW, 2, 0);
    run_inst(INST_BEQ, 0, 0);
    run_inst(INST_SB, 0, 0);
    run_inst(INST_JAL, 0, 1);
    run_inst(INST_J, 0, 0);
    run_inst(INST_JR, 0, 0);
    run_inst(INST_SW, DM_TO - 1, 2);
    run_inst(INST_LB, 1, 0);
    run_inst(6'h2A, 0, 0);

    // Randomized stream (HLT excluded); waits stay below the timeout.
    for (int i = 0; i < 60; i++) begin
      code = rinst();
      if (code == INST_HLT) code = INST_ADDU;
      run_inst(code, $urandom_range(0, DM_TO - 1), $urandom_range(0, 2));
    end

    // Three back-to-back ALU ops from reset: 12 cycles, 3 retires.
    do_reset();
    run_inst(INST_ADDU, 0, 0);
    run_inst(INST_ADDU, 0, 0);
    run_inst(INST_ADDU, 0, 0);
`ifdef SEQ_PERF_CNT_EN
    chk("perf_retire_3", retire_cnt, 32'd3);
    chk("perf_cycle_12", cycle_cnt, 32'd12);
`endif

    // DM timeout on a store that is never acknowledged.
    step("to_fetch", 1'b1, 1'b0, rinst(), ev(1, 0, 0, 0, 0, 0, 0, 3'd0), r);
    step("to_decode", rb(), 1'b0, INST_SW, ev(0, 0, 0, 0, 0, 0, 0, 3'd1), r);
    step("to_exec", rb(), 1'b0, INST_SW, ev(0, 0, 0, 0, 0, 0, 0, 3'd2), r);
    for (int k = 0; k < DM_TO; k++)
      step("to_mem_wait", rb(), 1'b0, INST_SW, ev(0, 0, 0, 1, 1, 0, 0, 3'd3), r);
    for (int k = 0; k < 3; k++)
      step("to_halt", rb(), rb(), INST_SW, ev(0, 0, 0, 0, 0, 1, 1, 3'd5), r);
    do_reset();

    // HLT: halted two cycles after fetch, then absorbs run/dm_ack activity.
    step("hlt_fetch", 1'b1, rb(), rinst(), ev(1, 0, 0, 0, 0, 0, 0, 3'd0), r);
    step("hlt_decode", rb(), rb(), INST_HLT, ev(0, 0, 0, 0, 0, 0, 0, 3'd1), r);
    step("hlt_enter", rb(), rb(), INST_HLT, ev(0, 0, 0, 0, 0, 1, 0, 3'd5), r);
    for (int k = 0; k < 20; k++)
      step("hlt_hold", rb(), rb(), rinst(), ev(0, 0, 0, 0, 0, 1, 0, 3'd5), r);
    do_reset();

    // Reset in the middle of a load's MEM wait drops dm_req at once.
    step("mr_fetch", 1'b1, 1'b0, rinst(), ev(1, 0, 0, 0, 0, 0, 0, 3'd0), r);
    step("mr_decode", rb(), 1'b0, INST_LW, ev(0, 0, 0, 0, 0, 0, 0, 3'd1), r);
    step("mr_exec", rb(), 1'b0, INST_LW, ev(0, 0, 0, 0, 0, 0, 0, 3'd2), r);
    step("mr_mem", rb(), 1'b0, INST_LW, ev(0, 0, 0, 0, 1, 0, 0, 3'd3), r);
    dm_ack = 1'b0;
    #1;
    chk("mr_req_before", {31'd0, dm_req}, 32'd1);
    do_reset();
    run_inst(INST_LW, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
